// File: rtl/noc_link_buffer.sv
// noc_link_buffer
// Clocked elastic buffer on a router output link. Packets arrive on a
// four-phase req/ack channel, are stored in a DEPTH-entry FIFO and are
// re-issued in arrival order on a second four-phase req/ack channel.
//
// Build option:
//   NOC_LINK_SYNC_EN - when defined, in_req and out_ack each pass through a
//                      2-flop synchronizer before the FSMs. in_data is not
//                      synchronized; it is bundled with in_req and held
//                      stable until in_ack is seen by the sender.
//
// Input FSM
//   state    | meaning
//   IN_IDLE  | waiting for in_req high with room in the FIFO
//   IN_ACK   | packet stored, in_ack high, waiting for in_req low
//
// Output FSM
//   state    | meaning
//   OUT_IDLE | out_req low, waiting for a stored packet
//   OUT_REQ  | out_data loaded, out_req high, waiting for out_ack high
//   OUT_WAIT | packet consumed, out_req low, waiting for out_ack low
module noc_link_buffer #(
  parameter int WIDTH_packet = 57,
  parameter int DEPTH        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_req,
  output logic                      in_ack,
  input  logic [WIDTH_packet-1:0]   in_data,
  output logic                      out_req,
  input  logic                      out_ack,
  output logic [WIDTH_packet-1:0]   out_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IN_IDLE,
    IN_ACK
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'b00,
    OUT_REQ  = 2'b01,
    OUT_WAIT = 2'b10
  } out_state_t;

  in_state_t  in_state, in_state_nxt;
  out_state_t out_state, out_state_nxt;

  logic [WIDTH_packet-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wptr;
  logic [PTR_W-1:0]        rptr;
  logic [CNT_W-1:0]        count_q;

  logic in_req_s;
  logic out_ack_s;
  logic push;
  logic pop;
  logic load;

`ifdef NOC_LINK_SYNC_EN
  logic [1:0] in_req_sync;
  logic [1:0] out_ack_sync;

  // Two-stage synchronizers for the asynchronous handshake levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_req_sync  <= 2'b00;
      out_ack_sync <= 2'b00;
    end else begin
      in_req_sync  <= {in_req_sync[0], in_req};
      out_ack_sync <= {out_ack_sync[0], out_ack};
    end
  end

  assign in_req_s  = in_req_sync[1];
  assign out_ack_s = out_ack_sync[1];
`else
  assign in_req_s  = in_req;
  assign out_ack_s = out_ack;
`endif

  // Input FSM next state; push is the single-cycle store strobe.
  always_comb begin
    in_state_nxt = in_state;
    push         = 1'b0;
    case (in_state)
      IN_IDLE: begin
        // A full FIFO simply leaves the request pending upstream.
        if (in_req_s && (count_q < FULL_CNT)) begin
          push         = 1'b1;
          in_state_nxt = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!in_req_s) begin
          in_state_nxt = IN_IDLE;
        end
      end
      default: in_state_nxt = IN_IDLE;
    endcase
  end

  // Output FSM next state; load captures the head, pop retires it.
  always_comb begin
    out_state_nxt = out_state;
    load          = 1'b0;
    pop           = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        if (count_q != '0) begin
          load          = 1'b1;
          out_state_nxt = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (out_ack_s) begin
          pop           = 1'b1;
          out_state_nxt = OUT_WAIT;
        end
      end
      OUT_WAIT: begin
        if (!out_ack_s) begin
          out_state_nxt = OUT_IDLE;
        end
      end
      default: out_state_nxt = OUT_IDLE;
    endcase
  end

  // State registers for both handshake FSMs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state  <= IN_IDLE;
      out_state <= OUT_IDLE;
    end else begin
      in_state  <= in_state_nxt;
      out_state <= out_state_nxt;
    end
  end

  // Pointers and occupancy move on the same edge; push and pop together
  // leave the occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Packet storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_data;
    end
  end

  // Output register is only reloaded in OUT_IDLE, so it is stable while
  // out_req is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= mem[rptr];
    end
  end

  assign in_ack  = (in_state == IN_ACK);
  assign out_req = (out_state == OUT_REQ);
  assign count   = count_q;

endmodule

// File: tb/tb_noc_link_buffer.sv
// Testbench for noc_link_buffer: randomized four-phase source and sink,
// a packet-order scoreboard, and an occupancy model built from observed
// handshakes.
module tb_noc_link_buffer;

  localparam int W     = 57;
  localparam int DEPTH = 4;
  localparam int TMO   = 200;
`ifdef NOC_LINK_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_req = 1'b0;
  logic                   in_ack;
  logic [W-1:0]           in_data = '0;
  logic                   out_req;
  logic                   out_ack = 1'b0;
  logic [W-1:0]           out_data;
  logic [$clog2(DEPTH):0] count;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  bit sink_hold = 1'b0;
  int sink_max  = 0;
  int n_acc     = 0;
  int n_done    = 0;

  noc_link_buffer #(.WIDTH_packet(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_req   (in_req),
    .in_ack   (in_ack),
    .in_data  (in_data),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .out_data (out_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] rand_pkt();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Sink and scoreboard: pops the expected packet whenever out_req is presented.
  initial begin : sink
    int st;
    int dly;
    logic [W-1:0] held;
    logic [W-1:0] e;
    st = 0;
    dly = 0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        out_ack = 1'b0;
        st = 0;
      end else begin
        case (st)
          0: if (out_req && !sink_hold) begin
            held = out_data;
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL out_unexpected actual=%h required=no_packet", out_data);
            end else begin
              e = exp_q.pop_front();
              chk("out_data_order", out_data, e);
            end
            dly = int'($urandom_range(sink_max, 0));
            if (dly == 0) begin
              out_ack = 1'b1;
              st = 2;
            end else begin
              st = 1;
            end
          end
          1: begin
            chk("out_data_stable", out_data, held);
            dly--;
            if (dly == 0) begin
              out_ack = 1'b1;
              st = 2;
            end
          end
          default: if (!out_req) begin
            out_ack = 1'b0;
            st = 0;
          end
        endcase
      end
    end
  end

  // Occupancy model: accepted packets minus completed output handshakes.
  initial begin : occ_mon
    logic pa;
    logic pr;
    pa = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_acc = 0;
        n_done = 0;
        pa = 1'b0;
        pr = 1'b0;
      end else begin
        if (in_ack && !pa) n_acc++;
        if (!out_req && pr) n_done++;
        pa = in_ack;
        pr = out_req;
        chk("count_occupancy", 64'(count), 64'(n_acc - n_done));
      end
    end
  end

  task automatic wait_in_ack(input logic lvl, input string name);
    int n;
    n = 0;
    while (in_ack !== lvl && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (in_ack !== lvl) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=%b required=%b", name, in_ack, lvl);
    end
  endtask

  task automatic start_send(input logic [W-1:0] p, input bit skew);
    if (skew) begin
      @(posedge clk);
      #3;
    end else begin
      @(negedge clk);
    end
    exp_q.push_back(p);
    in_data = p;
    in_req = 1'b1;
  endtask

  task automatic finish_send(input bit skew);
    wait_in_ack(1'b1, "in_ack_rise");
    if (skew) begin
      @(posedge clk);
      #3;
    end else begin
      @(negedge clk);
    end
    in_req = 1'b0;
    wait_in_ack(1'b0, "in_ack_fall");
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || count !== '0 || out_req !== 1'b0 || out_ack !== 1'b0)
           && n < TMO * 4) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_count_zero"}, 64'(count), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat;
    bit seen;
    logic [W-1:0] p;

    #3;
    chk("reset_in_ack", 64'(in_ack), 64'd0);
    chk("reset_out_req", 64'(out_req), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;

    // Single packet latency into an idle buffer, immediate-ack sink.
    sink_hold = 1'b0;
    sink_max = 0;
    @(negedge clk);
    p = 57'h0_1234_5678_9ABC;
    exp_q.push_back(p);
    in_data = p;
    in_req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (out_req !== 1'b1 && lat < TMO);
    chk("out_req_latency", 64'(lat), 64'(LAT));
    chk("single_out_data", 64'(out_data), 64'h0_1234_5678_9ABC);
    finish_send(1'b0);
    drain("single");

    // Blocked sink: four fill the FIFO, the fifth stays pending.
    sink_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      start_send(rand_pkt(), 1'b0);
      finish_send(1'b0);
    end
    start_send(rand_pkt(), 1'b0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (in_ack) seen = 1'b1;
    end
    chk("full_in_ack_held_low", 64'(seen), 64'd0);
    chk("full_count", 64'(count), 64'(DEPTH));
    sink_max = 1;
    sink_hold = 1'b0;
    finish_send(1'b0);
    drain("full");

    // Continuous random traffic.
    sink_max = 3;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) sink_max = 0;
      repeat ($urandom_range(2, 0)) @(negedge clk);
      start_send(rand_pkt(), 1'b0);
      finish_send(1'b0);
    end
    drain("random");

    // Simultaneous push and pop at occupancy 2.
    sink_hold = 1'b1;
    sink_max = 0;
    for (int i = 0; i < 2; i++) begin
      start_send(rand_pkt(), 1'b0);
      finish_send(1'b0);
    end
    @(negedge clk);
    chk("pushpop_count_before", 64'(count), 64'd2);
    chk("pushpop_out_req_before", 64'(out_req), 64'd1);
    @(negedge clk);
    p = rand_pkt();
    exp_q.push_back(p);
    in_data = p;
    in_req = 1'b1;
    sink_hold = 1'b0;
    wait_in_ack(1'b1, "pushpop_in_ack");
    chk("pushpop_count_after", 64'(count), 64'd2);
    chk("pushpop_out_req_after", 64'(out_req), 64'd0);
    finish_send(1'b0);
    drain("pushpop");

    // Reset mid-handshake with three packets stored.
    sink_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_send(rand_pkt(), 1'b0);
      finish_send(1'b0);
    end
    p = rand_pkt();
    start_send(p, 1'b0);
    wait_in_ack(1'b1, "rst_pre_in_ack");
    chk("rst_pre_count", 64'(count), 64'd3);
    chk("rst_pre_out_req", 64'(out_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ack", 64'(in_ack), 64'd0);
    chk("rst_mid_out_req", 64'(out_req), 64'd0);
    chk("rst_mid_out_data", 64'(out_data), 64'd0);
    chk("rst_mid_count", 64'(count), 64'd0);
    exp_q.delete();
    exp_q.push_back(p);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    sink_hold = 1'b0;
    finish_send(1'b0);
    drain("rst_reaccept");

    // Skewed source: request edges land 0.3 cycle after the clock edge.
    sink_max = 2;
    for (int i = 0; i < 50; i++) begin
      start_send(rand_pkt(), 1'b1);
      finish_send(1'b1);
    end
    drain("skew");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
